// File: rtl/pipeline_control.sv
// Pipeline stall/bubble controller with oldest-first stall/flush resolution and a halt/drain FSM.
// Define PIPE_PERF_EN to add the stall_cycles / flush_cycles performance counters.
module pipeline_control #(
    parameter int NumStages   = 6,
    parameter int DrainCycles = NumStages - 1,
    parameter int CntWidth    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NumStages-1:0] stallreq,
    input  logic [NumStages-1:0] flushreq,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [NumStages-1:0] stall,
    output logic [NumStages-1:0] bubble,
    output logic                 halted,
    output logic                 draining
`ifdef PIPE_PERF_EN
    ,
    output logic [CntWidth-1:0]  stall_cycles,
    output logic [CntWidth-1:0]  flush_cycles
`endif
);

    localparam int IdxW = $clog2(NumStages);
    localparam int DcW  = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
    localparam logic [DcW-1:0]       DrainLoad = DcW'(DrainCycles - 1);
    localparam logic [NumStages-1:0] Lsb       = NumStages'(1);
    localparam logic [NumStages-1:0] Bit1      = NumStages'(2);

    if (NumStages < 3 || NumStages > 16 || DrainCycles < 1 || CntWidth < 1) begin : g_bad_params
        $error("pipeline_control: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    function automatic logic [IdxW-1:0] top_index(input logic [NumStages-1:0] v);
        logic [IdxW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NumStages; i++) begin
            if (v[i]) idx = IdxW'(i);
        end
        return idx;
    endfunction

    function automatic logic [NumStages-1:0] below_mask(input logic [IdxW-1:0] n);
        logic [NumStages-1:0] m;
        for (int k = 0; k < NumStages; k++) begin
            m[k] = (IdxW'(k) < n);
        end
        return m;
    endfunction

    function automatic logic [NumStages-1:0] one_hot(input logic [IdxW-1:0] n);
        logic [NumStages-1:0] m;
        for (int k = 0; k < NumStages; k++) begin
            m[k] = (IdxW'(k) == n);
        end
        return m;
    endfunction

    state_t               state;
    logic [DcW-1:0]       cnt;
    logic [NumStages-1:0] flush_eff;
    logic                 s_valid;
    logic                 f_valid;
    logic                 flush_win;
    logic                 stall_win;
    logic                 older_stall;
    logic [IdxW-1:0]      s_idx;
    logic [IdxW-1:0]      f_idx;
    logic [NumStages-1:0] flush_bub;
    logic [NumStages-1:0] res_stall;
    logic [NumStages-1:0] res_bubble;
    logic [NumStages-1:0] drain_stall;

    // A flush from the PC stage itself has no younger work to kill, so bit 0 is dropped.
    always_comb begin
        flush_eff   = flushreq & ~Lsb;
        s_valid     = |stallreq;
        f_valid     = |flush_eff;
        s_idx       = top_index(stallreq);
        f_idx       = top_index(flush_eff);
        flush_win   = f_valid && (!s_valid || (s_idx < f_idx));
        stall_win   = s_valid && !flush_win;
        older_stall = |(stallreq & ~Lsb);
        flush_bub   = flush_win ? (below_mask(f_idx) & ~Lsb) : '0;
        res_stall   = '0;
        res_bubble  = flush_bub;
        if (stall_win) begin
            if (s_idx == '0) begin
                res_stall = Lsb;
            end else begin
                res_stall  = below_mask(s_idx);
                res_bubble = one_hot(s_idx);
            end
        end
    end

    // While draining, fetch is frozen and register 1 fills with bubbles unless an older stall holds it.
    always_comb begin
        stall       = '0;
        bubble      = '0;
        drain_stall = res_stall | Lsb;
        if (rst) begin
            case (state)
                ST_RUN: begin
                    stall  = res_stall;
                    bubble = res_bubble;
                end
                ST_DRAIN: begin
                    stall  = drain_stall;
                    bubble = (res_bubble | Bit1) & ~drain_stall;
                end
                ST_HALTED: begin
                    stall = '1;
                end
                default: begin
                    stall  = '0;
                    bubble = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            halted   <= 1'b0;
            draining <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state    <= ST_DRAIN;
                        cnt      <= DrainLoad;
                        draining <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (f_valid) begin
                        state    <= ST_RUN;
                        cnt      <= '0;
                        draining <= 1'b0;
                    end else if (!older_stall) begin
                        if (cnt == '0) begin
                            state    <= ST_HALTED;
                            halted   <= 1'b1;
                            draining <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    cnt      <= '0;
                    halted   <= 1'b0;
                    draining <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else if (state != ST_HALTED) begin
            if (|stall) stall_cycles <= stall_cycles + 1'b1;
            if (|flush_bub) flush_cycles <= flush_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed vector table, halt/drain sequences and a randomized run
// checked every cycle against a behavioural model of the resolution rules and halt FSM.
module tb_pipeline_control;

    localparam int N  = 6;
    localparam int DC = N - 1;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [N-1:0] stallreq;
    logic [N-1:0] flushreq;
    logic         halt_req;
    logic         resume;
    logic [N-1:0] stall;
    logic [N-1:0] bubble;
    logic         halted;
    logic         draining;
`ifdef PIPE_PERF_EN
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_cycles;
`endif

    pipeline_control #(.NumStages(N), .CntWidth(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq    (stallreq),
        .flushreq    (flushreq),
        .halt_req    (halt_req),
        .resume      (resume),
        .stall       (stall),
        .bubble      (bubble),
        .halted      (halted),
        .draining    (draining)
`ifdef PIPE_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_cycles(flush_cycles)
`endif
    );

    int checks;
    int failures;

    // Model: mode 0=run, 1=drain, 2=halted; m_left = drain cycles still owed.
    int           m_mode;
    int           m_left;
    int           m_sc;
    int           m_fc;
    logic [N-1:0] m_stall;
    logic [N-1:0] m_bubble;
    bit           m_fbub;

    typedef struct {
        logic [N-1:0] sreq;
        logic [N-1:0] freq;
        logic [N-1:0] exp_stall;
        logic [N-1:0] exp_bubble;
    } vec_t;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] s, input logic [N-1:0] f, input logic h, input logic r);
        stallreq = s;
        flushreq = f;
        halt_req = h;
        resume   = r;
    endtask

    task automatic model_comb();
        int s;
        int f;
        s = -1;
        f = -1;
        for (int i = 0; i < N; i++) if (stallreq[i]) s = i;
        for (int i = 1; i < N; i++) if (flushreq[i]) f = i;
        m_stall  = '0;
        m_bubble = '0;
        m_fbub   = 1'b0;
        if (!rst) return;
        if (m_mode == 2) begin
            m_stall = '1;
            return;
        end
        if (f >= 1 && s < f) begin
            m_bubble = N'((1 << f) - 2);
            m_fbub   = (f >= 2);
        end else if (s == 0) begin
            m_stall = N'(1);
        end else if (s > 0) begin
            m_stall  = N'((1 << s) - 1);
            m_bubble = N'(1 << s);
        end
        if (m_mode == 1) begin
            m_stall[0] = 1'b1;
            if (!m_stall[1]) m_bubble[1] = 1'b1;
        end
    endtask

    task automatic model_seq();
        if (!rst) begin
            m_mode = 0;
            m_left = 0;
            m_sc   = 0;
            m_fc   = 0;
        end else begin
            if (m_mode != 2) begin
                if (m_stall != '0) m_sc = (m_sc + 1) % (1 << CW);
                if (m_fbub) m_fc = (m_fc + 1) % (1 << CW);
            end
            case (m_mode)
                0: if (halt_req) begin
                    m_mode = 1;
                    m_left = DC;
                end
                1: if (|flushreq[N-1:1]) begin
                    m_mode = 0;
                end else if (!(|stallreq[N-1:1])) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
                2: if (resume) m_mode = 0;
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic settle();
        #4;
        model_comb();
        chk("stall", 32'(stall), 32'(m_stall));
        chk("bubble", 32'(bubble), 32'(m_bubble));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        chk("draining", 32'(draining), 32'(m_mode == 1));
`ifdef PIPE_PERF_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
        chk("flush_cycles", 32'(flush_cycles), 32'(m_fc));
`endif
    endtask

    task automatic adv();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        m_mode   = 0;
        m_left   = 0;
        m_sc     = 0;
        m_fc     = 0;
        rst      = 1'b0;
        drive('1, 6'b101010, 1'b1, 1'b0);
        vecs[0]  = '{6'b000100, 6'b000000, 6'b000011, 6'b000100};
        vecs[1]  = '{6'b000000, 6'b001000, 6'b000000, 6'b000110};
        vecs[2]  = '{6'b000100, 6'b001000, 6'b000000, 6'b000110};
        vecs[3]  = '{6'b010000, 6'b001000, 6'b001111, 6'b010000};
        vecs[4]  = '{6'b000001, 6'b000000, 6'b000001, 6'b000000};
        vecs[5]  = '{6'b000000, 6'b000001, 6'b000000, 6'b000000};
        vecs[6]  = '{6'b000000, 6'b000010, 6'b000000, 6'b000000};
        vecs[7]  = '{6'b100000, 6'b000000, 6'b011111, 6'b100000};
        vecs[8]  = '{6'b000000, 6'b100000, 6'b000000, 6'b011110};
        vecs[9]  = '{6'b001000, 6'b001000, 6'b000111, 6'b001000};
        vecs[10] = '{6'b111111, 6'b111111, 6'b011111, 6'b100000};
        vecs[11] = '{6'b000011, 6'b010000, 6'b000000, 6'b001110};
        vecs[12] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000};

        @(posedge clk);
        #1;
        // Reset: outputs forced quiet, FSM at RUN.
        settle();
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_bubble", 32'(bubble), 32'h0);
        adv();
        settle();
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_draining", 32'(draining), 32'h0);
        adv();
        rst = 1'b1;
        drive('0, '0, 1'b0, 1'b0);
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].sreq, vecs[i].freq, 1'b0, 1'b0);
            settle();
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_bubble", i), 32'(bubble), 32'(vecs[i].exp_bubble));
            adv();
        end

        // Halt pulse, clean drain of DC cycles, halt, resume with halt_req still high.
        drive('0, '0, 1'b1, 1'b0);
        step();
        drive('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < DC; i++) begin
            settle();
            chk("drain_flag", 32'(draining), 32'h1);
            chk("drain_stall", 32'(stall), 32'h01);
            chk("drain_bubble", 32'(bubble), 32'h02);
            adv();
        end
        settle();
        chk("halt_flag", 32'(halted), 32'h1);
        chk("halt_stall", 32'(stall), 32'h3f);
        adv();
        drive(6'b010101, 6'b001000, 1'b1, 1'b0);
        step();
        settle();
        chk("halt_ignores_inputs", 32'(halted), 32'h1);
        adv();
        drive('0, '0, 1'b1, 1'b1);
        step();
        drive('0, '0, 1'b1, 1'b0);
        settle();
        chk("resume_run_halted", 32'(halted), 32'h0);
        chk("resume_run_draining", 32'(draining), 32'h0);
        adv();
        drive('0, '0, 1'b0, 1'b0);
        settle();
        chk("reenter_drain", 32'(draining), 32'h1);
        adv();
        for (int i = 0; i < 20 && !halted; i++) step();
        drive('0, '0, 1'b0, 1'b1);
        step();
        drive('0, '0, 1'b0, 1'b0);
        step();

        // Older stall freezes the drain counter for 3 cycles.
        drive('0, '0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < DC + 3; i++) begin
            drive((i >= 1 && i <= 3) ? 6'b010000 : 6'b000000, '0, 1'b0, 1'b0);
            settle();
            chk("frz_draining", 32'(draining), 32'h1);
            if (i >= 1 && i <= 3) begin
                chk("frz_stall", 32'(stall), 32'h0f);
                chk("frz_bubble", 32'(bubble), 32'h10);
            end
            adv();
        end
        drive('0, '0, 1'b0, 1'b0);
        settle();
        chk("frz_halted", 32'(halted), 32'h1);
        adv();
        drive('0, '0, 1'b0, 1'b1);
        step();

        // Flush during drain aborts the halt.
        drive('0, '0, 1'b1, 1'b0);
        step();
        drive('0, '0, 1'b0, 1'b0);
        step();
        drive('0, 6'b001000, 1'b0, 1'b0);
        settle();
        chk("dflush_stall", 32'(stall), 32'h01);
        chk("dflush_bubble", 32'(bubble), 32'h06);
        adv();
        drive('0, '0, 1'b0, 1'b0);
        settle();
        chk("dflush_draining", 32'(draining), 32'h0);
        chk("dflush_halted", 32'(halted), 32'h0);
        adv();

        // Reset mid-drain, then mid-halt.
        drive('0, '0, 1'b1, 1'b0);
        step();
        drive('0, '0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        settle();
        chk("rstd_stall", 32'(stall), 32'h0);
        chk("rstd_bubble", 32'(bubble), 32'h0);
        adv();
        rst = 1'b1;
        settle();
        chk("rstd_draining", 32'(draining), 32'h0);
        adv();
        drive('0, '0, 1'b1, 1'b0);
        step();
        drive('0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !halted; i++) step();
        settle();
        chk("rsth_pre", 32'(halted), 32'h1);
        rst = 1'b0;
        adv();
        rst = 1'b1;
        settle();
        chk("rsth_halted", 32'(halted), 32'h0);
`ifdef PIPE_PERF_EN
        chk("rsth_stall_cycles", 32'(stall_cycles), 32'h0);
        chk("rsth_flush_cycles", 32'(flush_cycles), 32'h0);
`endif
        adv();

`ifdef PIPE_PERF_EN
        // 17 stall cycles wrap a 4-bit counter to 1; three flush cycles with bubbles count 3.
        drive(6'b000100, '0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) step();
        drive('0, 6'b001000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        drive('0, '0, 1'b0, 1'b0);
        settle();
        chk("perf_stall_wrap", 32'(stall_cycles), 32'h1);
        chk("perf_flush", 32'(flush_cycles), 32'h3);
        adv();
`endif

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 60) != 0);
            stallreq = ($urandom_range(0, 2) == 0) ? (N'($urandom) & N'($urandom)) : '0;
            flushreq = ($urandom_range(0, 5) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            halt_req = ($urandom_range(0, 7) == 0);
            resume   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
- Parametrised successor to the fixed six-signal stall controller used by the current five-stage core.
- Generalises to NumStages pipeline registers with per-stage stall and flush (bubble) requests, oldest-first priority resolution and a sequential halt/drain FSM.
- Sits beside the datapath and drives every pipeline flop's stall and bubble-load inputs.
- Index 0 is the PC register; register k is written by stage k, which reads register k-1.

Parameters:
- NumStages, 6, number of pipeline registers including the PC; must be 3..16.
- DrainCycles, NumStages-1, cycles spent in DRAIN before entering HALTED.
- CntWidth, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset: rst=0 resets at the clk edge.
- stallreq  in  NumStages  bit i=1: stage i cannot complete this cycle.
- flushreq  in  NumStages  bit i=1: stage i redirects the PC; younger stages hold wrong-path work.
- halt_req  in  1  request an orderly halt (WFI or illegal decode); level-sensitive.
- resume  in  1  leave HALTED.
- stall  out  NumStages  bit k=1: register k holds its value.
- bubble  out  NumStages  bit k=1: register k loads NOP/zero instead of d.
- halted  out  1  FSM is in HALTED.
- draining  out  1  FSM is in DRAIN.
- stall_cycles  out  CntWidth  only with PIPE_PERF_EN.
- flush_cycles  out  CntWidth  only with PIPE_PERF_EN.

Behaviour:
- Stall and bubble are combinational from the inputs and the FSM state. The only state is the FSM, the drain counter and the optional counters.
- Reset (rst=0): state RUN, counter 0, halted=0, draining=0, perf counters 0. While rst=0, stall=0 and bubble=0; the flops apply their own reset values.
- Priority resolution, RUN state:
  - s = highest i with stallreq[i]=1; f = highest i with flushreq[i]=1.
  - Only f>=1 is meaningful; flushreq[0] is ignored.
- Flush only (f valid, and no stall or s<f): bubble[k]=1 for 1<=k<=f-1. stall=0. Register 0 takes the redirect PC.
- Stall only (s valid, and no flush or s>=f): stall[k]=1 for 0<=k<=s-1; bubble[s]=1 when s>=1; registers above s advance. If s=0, only stall[0]=1.
- Both, f>s: the flush wins and the stall request is dropped, because the stalling stage is wrong-path.
- Both, s>=f: the stall wins. The flush request is re-presented by its stage on the next cycle; the controller holds no memory of it.
- stall and bubble are never both 1 for the same k.
- FSM transitions:
  - RUN -> DRAIN when halt_req=1. Counter loads DrainCycles-1. Normal resolution applies in this cycle.
  - DRAIN: stall[0]=1 and bubble[1]=1 force fetch to stop. Older stages keep normal stall/flush resolution, with results OR-ed in except for bubble[1]. The counter decrements only in cycles with no stallreq at index >=1.
  - DRAIN -> HALTED when the counter is 0 and no stallreq at index >=1. A flushreq during DRAIN returns the FSM to RUN with the counter cleared (the halt was on a wrong path).
  - HALTED: stall = all ones, bubble = 0, halted=1. Other inputs are ignored.
  - HALTED -> RUN when resume=1. resume has priority over a still-asserted halt_req for one cycle; re-entry to DRAIN happens the following cycle if halt_req is still 1.
- halt_req while already in DRAIN or HALTED is ignored.
- Reset mid-DRAIN or mid-HALTED returns to RUN immediately.

Optional Feature:
- Macro: PIPE_PERF_EN.
- Defined: stall_cycles increments every cycle with stall!=0 in RUN or DRAIN; flush_cycles increments every cycle with bubble!=0 caused by a flushreq. Both wrap modulo 2^CntWidth, are frozen in HALTED and cleared by reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- NumStages=6, stallreq=6'b000100 (stage 2) -> stall=6'b000011, bubble=6'b000100.
- flushreq=6'b001000 (stage 3 branch) -> bubble=6'b000110, stall=0.
- stallreq stage 2 plus flushreq stage 3 -> flush wins: bubble=6'b000110, stall=0. stallreq stage 4 plus flushreq stage 3 -> stall=6'b001111, bubble=6'b010000.
- halt_req pulse with DrainCycles=5 and no stalls:
  - draining=1 for 5 cycles with stall[0]=1 and bubble[1]=1;
  - then halted=1 and stall=6'b111111;
  - resume=1 -> RUN next cycle.
- In DRAIN, stallreq[4] for 3 cycles -> the counter freezes and HALTED arrives 3 cycles later. flushreq[3] in DRAIN -> RUN, draining=0.
- PIPE_PERF_EN, CntWidth=4: 17 stall cycles -> stall_cycles=1 (wrap). rst=0 mid-HALTED -> halted=0 and counters 0 on the next edge.
